// File: rtl/instr_encoder_loader_if.sv
// Field-bundle handshake and instruction-memory write bus of instr_encoder_loader.
// master = bundle producer / memory side, slave = the encoder.
interface instr_encoder_loader_if #(
    parameter int ADDR_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        op_sel;
    logic [4:0]        rd;
    logic [4:0]        rn;
    logic [4:0]        rm;
    logic [31:0]       imm;
    logic [1:0]        hw;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, op_sel, rd, rn, rm, imm, hw, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, op_sel, rd, rn, rm, imm, hw, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// LEGv8 instruction encoder: range-checks a field bundle, encodes it and streams
// legal words to consecutive instruction-memory byte addresses.
module instr_encoder_loader #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256
) (
    input  logic                  CLK,
    input  logic                  resetl,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic                  finish,
    instr_encoder_loader_if.slave bus,
    output logic [15:0]           word_count,
    output logic                  err,
    output logic [7:0]            err_count,
    output logic                  busy,
    output logic                  full
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [CNT_W-1:0]  acc_count;
    logic              legal;
    logic [31:0]       enc_word;
    logic              accept;
    logic              wr_done;

    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        bus.in_ready = 1'b0;
        case (state_q)
            IDLE, DONE: if (start) state_d = ACTIVE;
            ACTIVE: begin
                if (!start && finish) state_d = DONE;
                bus.in_ready = !full && !start && !finish && (!we_q || bus.imem_ready);
            end
            default: state_d = IDLE;
        endcase
    end

    // Signed ranges are checked as "all bits above the field equal its sign bit".
    always_comb begin
        legal    = 1'b1;
        enc_word = '0;
        case (bus.op_sel)
            4'd0: enc_word = {11'b10001010000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd1: enc_word = {11'b10101010000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd2: enc_word = {11'b10001011000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd3: enc_word = {11'b11001011000, bus.rm, 6'b0, bus.rn, bus.rd};
            4'd4, 4'd5: begin
                enc_word = {(bus.op_sel == 4'd4) ? 10'b1001000100 : 10'b1101000100,
                            bus.imm[11:0], bus.rn, bus.rd};
                legal    = (bus.imm[31:12] == '0);
            end
            4'd6: begin
                enc_word = {6'b000101, bus.imm[25:0]};
                legal    = (bus.imm[31:25] == '0) || (bus.imm[31:25] == '1);
            end
            4'd7: begin
                enc_word = {8'b10110100, bus.imm[18:0], bus.rd};
                legal    = (bus.imm[31:18] == '0) || (bus.imm[31:18] == '1);
            end
            4'd8, 4'd9: begin
                enc_word = {(bus.op_sel == 4'd8) ? 11'b11111000010 : 11'b11111000000,
                            bus.imm[8:0], 2'b00, bus.rn, bus.rd};
                legal    = (bus.imm[31:8] == '0) || (bus.imm[31:8] == '1);
            end
            4'd10: begin
                enc_word = {9'b110100101, bus.hw, bus.imm[15:0], bus.rd};
                legal    = (bus.imm[31:16] == '0);
            end
            default: legal = 1'b0;
        endcase
    end

    assign accept  = bus.in_valid && bus.in_ready;
    assign wr_done = we_q && bus.imem_ready;

    // A completing write and a new accept can share an edge; the accept's we_q wins.
    always_ff @(posedge CLK or negedge resetl) begin
        if (!resetl) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            full       <= 1'b0;
            acc_count  <= '0;
        end else if (start) begin
            addr_q     <= base_addr & ~ADDR_W'(3);
            we_q       <= 1'b0;
            word_count <= '0;
            err        <= 1'b0;
            err_count  <= '0;
            full       <= 1'b0;
            acc_count  <= '0;
        end else begin
            if (wr_done) begin
                we_q       <= 1'b0;
                addr_q     <= addr_q + ADDR_W'(4);
                word_count <= word_count + 16'd1;
            end
            if (accept) begin
                if (legal) begin
                    we_q      <= 1'b1;
                    wdata_q   <= enc_word;
                    acc_count <= acc_count + CNT_W'(1);
                    if (acc_count == CNT_W'(DEPTH - 1)) full <= 1'b1;
                end else begin
                    err <= 1'b1;
                    if (err_count != '1) err_count <= err_count + 8'd1;
                end
            end
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy           = (state_q == ACTIVE) || we_q;
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader: directed scenarios plus randomized
// sessions checked against a queue-based encoding model.
module tb_instr_encoder_loader;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              resetl;
    logic              start;
    logic              finish;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       word_count;
    logic              err;
    logic [7:0]        err_count;
    logic              busy;
    logic              full;

    int tests = 0;
    int fails = 0;

    instr_encoder_loader_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .CLK        (CLK),
        .resetl     (resetl),
        .start      (start),
        .base_addr  (base_addr),
        .finish     (finish),
        .bus        (bus),
        .word_count (word_count),
        .err        (err),
        .err_count  (err_count),
        .busy       (busy),
        .full       (full)
    );

    always #5 CLK = ~CLK;

    // Reference encoder: {legal, word} built from opcode constants with plain arithmetic.
    function automatic logic [32:0] model_encode(input logic [3:0] op, input logic [4:0] rd,
                                                 input logic [4:0] rn, input logic [4:0] rm,
                                                 input logic [31:0] imm, input logic [1:0] hw);
        int          si;
        logic [31:0] w;
        logic [31:0] opc;
        bit          ok;
        si = $signed(imm);
        ok = 1'b1;
        w  = 32'd0;
        case (op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                opc = (op == 4'd0) ? 32'h450 : (op == 4'd1) ? 32'h550 : (op == 4'd2) ? 32'h458 : 32'h658;
                w = (opc << 21) | (32'(rm) << 16) | (32'(rn) << 5) | 32'(rd);
            end
            4'd4, 4'd5: begin
                ok = (si >= 0) && (si <= 4095);
                opc = (op == 4'd4) ? 32'h244 : 32'h344;
                w = (opc << 22) | ((32'(si) & 32'hFFF) << 10) | (32'(rn) << 5) | 32'(rd);
            end
            4'd6: begin
                ok = (si >= -33554432) && (si <= 33554431);
                w = (32'h5 << 26) | (32'(si) & 32'h3FFFFFF);
            end
            4'd7: begin
                ok = (si >= -262144) && (si <= 262143);
                w = (32'hB4 << 24) | ((32'(si) & 32'h7FFFF) << 5) | 32'(rd);
            end
            4'd8, 4'd9: begin
                ok = (si >= -256) && (si <= 255);
                opc = (op == 4'd8) ? 32'h7C2 : 32'h7C0;
                w = (opc << 21) | ((32'(si) & 32'h1FF) << 12) | (32'(rn) << 5) | 32'(rd);
            end
            4'd10: begin
                ok = (si >= 0) && (si <= 65535);
                w = (32'h1A5 << 23) | (32'(hw) << 21) | ((32'(si) & 32'hFFFF) << 5) | 32'(rd);
            end
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_bundle(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rn,
                              input logic [4:0] rm, input logic [31:0] imm, input logic [1:0] hw);
        bus.op_sel   = op;
        bus.rd       = rd;
        bus.rn       = rn;
        bus.rm       = rm;
        bus.imm      = imm;
        bus.hw       = hw;
        bus.in_valid = 1'b1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        bus.in_valid = 1'b0;
        base_addr    = b;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic test_reset();
        resetl = 1'b0; start = 1'b0; finish = 1'b0; base_addr = '0;
        bus.in_valid = 1'b0; bus.imem_ready = 1'b0;
        set_bundle(4'd2, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        bus.in_valid = 1'b0;
        #22;
        tests++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL reset_we: got %b want 0", bus.imem_we); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.imem_addr !== 16'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
        tests++; if (bus.imem_wdata !== 32'h0) begin fails++; $display("FAIL reset_wdata: got %h want 0", bus.imem_wdata); end
        tests++; if ({word_count, err, err_count, busy, full} !== 27'd0) begin
            fails++; $display("FAIL reset_counters: got wc=%0d err=%b ec=%0d busy=%b full=%b want all 0",
                              word_count, err, err_count, busy, full);
        end
        tick();
        resetl = 1'b1;
        tick();
        bus.in_valid = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL idle_in_ready: got %b want 0", bus.in_ready); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_start(16'h0040);
        bus.imem_ready = 1'b1;
        set_bundle(4'd2, 5'd3, 5'd1, 5'd2, 32'd0, 2'd0);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL t1_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_we !== 1'b1) begin fails++; $display("FAIL t1_we: got %b want 1", bus.imem_we); end
        tests++; if (bus.imem_addr !== 16'h0040) begin fails++; $display("FAIL t1_addr: got %h want 0040", bus.imem_addr); end
        tests++; if (bus.imem_wdata !== 32'h8B020023) begin fails++; $display("FAIL t1_wdata: got %h want 8b020023", bus.imem_wdata); end
        tick();
        tests++; if (word_count !== 16'd1) begin fails++; $display("FAIL t1_count: got %0d want 1", word_count); end
        tests++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL t1_we_drop: got %b want 0", bus.imem_we); end
    endtask

    task automatic test_back_to_back();
        do_start(16'h0040);
        bus.imem_ready = 1'b1;
        set_bundle(4'd8, 5'd5, 5'd2, 5'd0, 32'd8, 2'd0);
        tick();
        set_bundle(4'd6, 5'd0, 5'd0, 5'd0, -32'sd2, 2'd0);
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL t2_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.imem_addr !== 16'h0040 || bus.imem_wdata !== 32'hF8408045) begin
            fails++; $display("FAIL t2_first: got %h@%h want f8408045@0040", bus.imem_wdata, bus.imem_addr);
        end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'h0044 || bus.imem_wdata !== 32'h17FFFFFE) begin
            fails++; $display("FAIL t2_second: got we=%b %h@%h want 17fffffe@0044", bus.imem_we, bus.imem_wdata, bus.imem_addr);
        end
        tick();
        tests++; if (word_count !== 16'd2) begin fails++; $display("FAIL t2_count: got %0d want 2", word_count); end
    endtask

    task automatic test_formats();
        do_start(16'h0100);
        bus.imem_ready = 1'b1;
        set_bundle(4'd7, 5'd7, 5'd0, 5'd0, 32'd3, 2'd0);
        tick();
        set_bundle(4'd10, 5'd9, 5'd0, 5'd0, 32'h1234, 2'd1);
        tests++; if (bus.imem_wdata !== 32'hB4000067) begin fails++; $display("FAIL t3_cbz: got %h want b4000067", bus.imem_wdata); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_wdata !== 32'hD2A24689) begin fails++; $display("FAIL t3_movz: got %h want d2a24689", bus.imem_wdata); end
        tick();
    endtask

    task automatic test_reject();
        do_start(16'h0040);
        bus.imem_ready = 1'b1;
        set_bundle(4'd4, 5'd1, 5'd1, 5'd0, 32'd4096, 2'd0);
        tick();
        tests++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL t4_addi_we: got %b want 0", bus.imem_we); end
        set_bundle(4'd12, 5'd1, 5'd1, 5'd1, 32'd0, 2'd0);
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_we !== 1'b0) begin fails++; $display("FAIL t4_op_we: got %b want 0", bus.imem_we); end
        tests++; if (err !== 1'b1 || err_count !== 8'd2) begin fails++; $display("FAIL t4_err: got err=%b ec=%0d want 1/2", err, err_count); end
        tests++; if (bus.imem_addr !== 16'h0040) begin fails++; $display("FAIL t4_addr_hold: got %h want 0040", bus.imem_addr); end
        set_bundle(4'd0, 5'd4, 5'd5, 5'd6, 32'd0, 2'd0);
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== 16'h0040) begin
            fails++; $display("FAIL t4_next: got we=%b addr=%h want 1/0040", bus.imem_we, bus.imem_addr);
        end
        tick();
    endtask

    task automatic test_stall();
        do_start(16'h0200);
        bus.imem_ready = 1'b0;
        set_bundle(4'd1, 5'd2, 5'd3, 5'd4, 32'd0, 2'd0);
        tick();
        set_bundle(4'd3, 5'd5, 5'd6, 5'd7, 32'd0, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (bus.in_ready !== 1'b0 || bus.imem_we !== 1'b1 || bus.imem_addr !== 16'h0200 ||
                         bus.imem_wdata !== 32'hAA040062) begin
                fails++; $display("FAIL t5_stall%0d: got rdy=%b we=%b %h@%h want 0/1 aa040062@0200",
                                  i, bus.in_ready, bus.imem_we, bus.imem_wdata, bus.imem_addr);
            end
            tick();
        end
        bus.in_valid   = 1'b0;
        bus.imem_ready = 1'b1;
        tick();
        tick();
        tests++; if (word_count !== 16'd1 || bus.imem_we !== 1'b0) begin
            fails++; $display("FAIL t5_one_write: got wc=%0d we=%b want 1/0", word_count, bus.imem_we);
        end
    endtask

    task automatic test_full();
        do_start(16'h0000);
        bus.imem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_bundle(4'd2, 5'(i), 5'd1, 5'd2, 32'd0, 2'd0);
            #1;
            tests++; if (bus.in_ready !== (i < DEPTH)) begin
                fails++; $display("FAIL t6_ready%0d: got %b want %b", i, bus.in_ready, (i < DEPTH));
            end
            tick();
        end
        tests++; if (word_count !== 16'(DEPTH) || full !== 1'b1 || bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL t6_full: got wc=%0d full=%b rdy=%b want %0d/1/0", word_count, full, bus.in_ready, DEPTH);
        end
        do_start(16'h0000);
        tests++; if (word_count !== 16'd0 || full !== 1'b0) begin
            fails++; $display("FAIL t6_restart: got wc=%0d full=%b want 0/0", word_count, full);
        end
    endtask

    task automatic test_wrap();
        do_start(16'hFFFF);
        bus.imem_ready = 1'b1;
        set_bundle(4'd2, 5'd1, 5'd1, 5'd1, 32'd0, 2'd0);
        tick();
        tests++; if (bus.imem_addr !== 16'hFFFC) begin fails++; $display("FAIL wrap_first: got %h want fffc", bus.imem_addr); end
        tick();
        bus.in_valid = 1'b0;
        tests++; if (bus.imem_addr !== 16'h0000) begin fails++; $display("FAIL wrap_second: got %h want 0000", bus.imem_addr); end
        tick();
    endtask

    task automatic test_finish_pending();
        do_start(16'h0080);
        bus.imem_ready = 1'b0;
        set_bundle(4'd2, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);
        tick();
        finish = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL fin_ready: got %b want 0", bus.in_ready); end
        tick();
        finish = 1'b0;
        tests++; if (busy !== 1'b1 || bus.imem_we !== 1'b1) begin
            fails++; $display("FAIL fin_pending: got busy=%b we=%b want 1/1", busy, bus.imem_we);
        end
        bus.imem_ready = 1'b1;
        tick();
        tests++; if (word_count !== 16'd1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            fails++; $display("FAIL fin_done: got wc=%0d busy=%b rdy=%b want 1/0/0", word_count, busy, bus.in_ready);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_start(16'h0080);
        bus.imem_ready = 1'b0;
        set_bundle(4'd2, 5'd1, 5'd2, 5'd3, 32'd0, 2'd0);
        tick();
        bus.in_valid = 1'b0;
        #1;
        resetl = 1'b0;
        #1;
        tests++; if (bus.imem_we !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_reset: got we=%b busy=%b want 0/0", bus.imem_we, busy);
        end
        tick();
        resetl = 1'b1;
        tick();
    endtask

    task automatic test_err_saturate();
        do_start(16'h0000);
        set_bundle(4'd15, 5'd0, 5'd0, 5'd0, 32'd0, 2'd0);
        for (int i = 0; i < 260; i++) tick();
        bus.in_valid = 1'b0;
        tests++; if (err_count !== 8'd255 || err !== 1'b1 || word_count !== 16'd0) begin
            fails++; $display("FAIL err_sat: got ec=%0d err=%b wc=%0d want 255/1/0", err_count, err, word_count);
        end
    endtask

    task automatic test_random();
        int edges[14] = '{0, 4095, 4096, 255, 256, -256, -257, 65535, 65536,
                          33554431, 33554432, -33554432, 262143, 262144};
        logic [31:0] exp_q[$];
        logic [32:0] enc;
        logic [15:0] exp_addr;
        logic [31:0] rimm;
        int acc, errs, wc, guard;
        bit exp_rdy;
        for (int s = 0; s < 8; s++) begin
            base_addr = 16'($urandom);
            exp_addr  = base_addr & 16'hFFFC;
            exp_q.delete();
            acc = 0; errs = 0; wc = 0;
            do_start(base_addr);
            for (int c = 0; c < 30; c++) begin
                case ($urandom_range(0, 3))
                    0: rimm = $urandom;
                    1: rimm = $urandom_range(0, 4200);
                    2: rimm = -$urandom_range(0, 300);
                    default: rimm = edges[$urandom_range(0, 13)];
                endcase
                set_bundle(4'($urandom_range(0, 15)), 5'($urandom), 5'($urandom), 5'($urandom), rimm, 2'($urandom));
                bus.in_valid   = ($urandom_range(0, 3) != 0);
                bus.imem_ready = ($urandom_range(0, 3) != 0);
                #1;
                exp_rdy = (acc < DEPTH) && (exp_q.size() == 0 || bus.imem_ready);
                tests++; if (bus.in_ready !== exp_rdy) begin
                    fails++; $display("FAIL rnd_ready s%0d c%0d: got %b want %b", s, c, bus.in_ready, exp_rdy);
                end
                tests++; if (bus.imem_we !== (exp_q.size() != 0)) begin
                    fails++; $display("FAIL rnd_we s%0d c%0d: got %b want %b", s, c, bus.imem_we, exp_q.size() != 0);
                end
                if (exp_q.size() != 0) begin
                    tests++; if (bus.imem_addr !== exp_addr || bus.imem_wdata !== exp_q[0]) begin
                        fails++; $display("FAIL rnd_write s%0d c%0d: got %h@%h want %h@%h",
                                          s, c, bus.imem_wdata, bus.imem_addr, exp_q[0], exp_addr);
                    end
                    if (bus.imem_ready) begin
                        void'(exp_q.pop_front());
                        exp_addr = exp_addr + 16'd4;
                        wc++;
                    end
                end
                if (bus.in_valid && exp_rdy) begin
                    enc = model_encode(bus.op_sel, bus.rd, bus.rn, bus.rm, bus.imm, bus.hw);
                    if (enc[32]) begin
                        exp_q.push_back(enc[31:0]);
                        acc++;
                    end else if (errs < 255) begin
                        errs++;
                    end
                end
                tick();
            end
            bus.in_valid   = 1'b0;
            bus.imem_ready = 1'b1;
            guard = 0;
            while (exp_q.size() != 0 && guard < 8) begin
                tests++; if (bus.imem_we !== 1'b1 || bus.imem_addr !== exp_addr || bus.imem_wdata !== exp_q[0]) begin
                    fails++; $display("FAIL rnd_drain s%0d: got we=%b %h@%h want %h@%h",
                                      s, bus.imem_we, bus.imem_wdata, bus.imem_addr, exp_q[0], exp_addr);
                end
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 16'd4;
                wc++;
                guard++;
                tick();
            end
            tests++; if (word_count !== 16'(wc) || err_count !== 8'(errs) || err !== (errs != 0) || full !== (acc == DEPTH)) begin
                fails++; $display("FAIL rnd_session s%0d: got wc=%0d ec=%0d err=%b full=%b want %0d/%0d/%b/%b",
                                  s, word_count, err_count, err, full, wc, errs, errs != 0, acc == DEPTH);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_formats();
        test_reject();
        test_stall();
        test_full();
        test_wrap();
        test_finish_pending();
        test_async_reset();
        test_err_saturate();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        fails++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
